nrs_ls_est_buf: RTL

Parametrised least-squares pilot de-rotation unit for NB-IoT channel estimation. Streams received NRS resource elements in and multiplies each by the conjugate of its QPSK pilot, ±1/√2 per axis, scaled to NRS_MAG in Q(FRAC) format. It writes the result into a DEPTH-entry estimate buffer, directly or averaged with the stored entry, and serves random reads to the interpolator downstream.
Successor to the single-entry, fixed-width multiplier. Adds:
- valid handshake
- parametrised depth
- averaging mode
- entry-valid tracking
- streaming output

---
 rtl/nb_chest_pkg.sv | 19 +
 rtl/nrs_const_mult.sv | 34 +++
 rtl/nrs_ls_est_buf.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/nb_chest_pkg.sv
// Shared constants for the NB-IoT channel-estimation blocks.
//   FRAC     : fractional bits of the pilot magnitude
//   NRS_MAG  : round(2^FRAC / sqrt(2)), QPSK pilot magnitude per axis
//   NRS_POS / NRS_NEG : pilot sign encoding (0 = +NRS_MAG, 1 = -NRS_MAG)
//   out_w_of : estimate output width derived from the input sample width
package nb_chest_pkg;

    localparam int   FRAC    = 11;
    localparam int   NRS_MAG = 1448;
    localparam logic NRS_POS = 1'b0;
    localparam logic NRS_NEG = 1'b1;

    // Inner sum is one bit wider than the input; scaling by NRS_MAG/2^FRAC
    // (< 1) never grows it further.
    function automatic int out_w_of(input int width_r_i);
        return width_r_i + 1;
    endfunction

endpackage

// File: rtl/nrs_const_mult.sv
// Constant multiply by MAG using shift-add, followed by an arithmetic
// right shift by FRAC (floor, no rounding).
//   din  : signed operand, IN_W bits
//   dout : signed (din * MAG) >>> FRAC, truncated to OUT_W bits
// MAG must be below 2^FRAC so the product fits in IN_W+FRAC bits.
module nrs_const_mult
    import nb_chest_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int OUT_W = 17,
    parameter int MAG   = 1448,
    parameter int FRAC  = 11
)(
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam int PW = IN_W + FRAC;

    logic signed [PW-1:0] dext;
    logic signed [PW-1:0] acc;

    assign dext = PW'(din);

    always_comb begin
        acc = '0;
        for (int k = 0; k < FRAC; k++) begin
            if (MAG[k]) acc = acc + (dext <<< k);
        end
    end

    assign dout = OUT_W'(acc >>> FRAC);

endmodule

// File: rtl/nrs_ls_est_buf.sv
// LS pilot de-rotation with a DEPTH-entry estimate buffer.
// Each received NRS RE is multiplied by the conjugate of its QPSK pilot,
// written (or averaged) into the buffer two edges later and streamed out.
//   clk, rst (async active-low), en (global freeze when low)
//   in_valid, rx_r, rx_i, nrs_r, nrs_i, wr_addr, avg_mode : write stream
//   clr                                   : clear all entry-valid bits
//   out_valid, out_real, out_imag         : value written by stage 2
//   rd_en, rd_addr                        : random read request
//   rd_valid, rd_hit, rd_real, rd_imag    : registered read response
module nrs_ls_est_buf
    import nb_chest_pkg::*;
#(
    parameter int WIDTH_R_I = 16,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int FRAC      = nb_chest_pkg::FRAC,
    parameter int NRS_MAG   = nb_chest_pkg::NRS_MAG,
    parameter int OUT_W     = out_w_of(WIDTH_R_I)
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic signed [WIDTH_R_I-1:0] rx_r,
    input  logic signed [WIDTH_R_I-1:0] rx_i,
    input  logic                        nrs_r,
    input  logic                        nrs_i,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic                        avg_mode,
    input  logic                        clr,
    output logic                        out_valid,
    output logic signed [OUT_W-1:0]     out_real,
    output logic signed [OUT_W-1:0]     out_imag,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_valid,
    output logic                        rd_hit,
    output logic signed [OUT_W-1:0]     rd_real,
    output logic signed [OUT_W-1:0]     rd_imag
);

    // One guard bit over the nominal W+1: with both inputs at -2^(W-1) and
    // both pilots negative the sum reaches +2^W, which W+1 bits cannot hold.
    localparam int SW = WIDTH_R_I + 2;

    logic signed [SW-1:0]    xr, xi, sum_re, sum_im;
    logic                    s1_vld, s1_avg;
    logic signed [SW-1:0]    s1_re, s1_im;
    logic [ADDR_W-1:0]       s1_addr;
    logic signed [OUT_W-1:0] res_re, res_im, wr_re, wr_im;
    logic signed [OUT_W:0]   avg_re, avg_im;
    logic                    prev_vld;

    logic signed [OUT_W-1:0] buf_re [DEPTH];
    logic signed [OUT_W-1:0] buf_im [DEPTH];
    logic [DEPTH-1:0]        ent_vld;

    // Stage 1: sign-combine rx with the conjugate pilot.
    assign xr = SW'(rx_r);
    assign xi = SW'(rx_i);

    always_comb begin
        sum_re = ((nrs_r == NRS_NEG) ? -xr : xr) + ((nrs_i == NRS_NEG) ? -xi : xi);
        sum_im = ((nrs_r == NRS_NEG) ? -xi : xi) - ((nrs_i == NRS_NEG) ? -xr : xr);
    end

    // Stage 2: constant scale, then optional average with the stored entry.
    nrs_const_mult #(.IN_W(SW), .OUT_W(OUT_W), .MAG(NRS_MAG), .FRAC(FRAC)) u_mult_re (
        .din  (s1_re),
        .dout (res_re)
    );

    nrs_const_mult #(.IN_W(SW), .OUT_W(OUT_W), .MAG(NRS_MAG), .FRAC(FRAC)) u_mult_im (
        .din  (s1_im),
        .dout (res_im)
    );

    // The buffer is updated on the same edge that retires stage 2, so a
    // following stage 2 on the same address already sees the fresh entry.
    // A concurrent clr makes the entry count as never written.
    always_comb begin
        prev_vld = ent_vld[s1_addr] & ~clr;
        avg_re   = ((OUT_W+1)'(buf_re[s1_addr]) + (OUT_W+1)'(res_re)) >>> 1;
        avg_im   = ((OUT_W+1)'(buf_im[s1_addr]) + (OUT_W+1)'(res_im)) >>> 1;
        wr_re    = res_re;
        wr_im    = res_im;
        if (s1_avg && prev_vld) begin
            wr_re = OUT_W'(avg_re);
            wr_im = OUT_W'(avg_im);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld    <= 1'b0;
            s1_avg    <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s1_addr   <= '0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            rd_valid  <= 1'b0;
            rd_hit    <= 1'b0;
            rd_real   <= '0;
            rd_imag   <= '0;
            ent_vld   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_re[i] <= '0;
                buf_im[i] <= '0;
            end
        end else if (en) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_re   <= sum_re;
                s1_im   <= sum_im;
                s1_addr <= wr_addr;
                s1_avg  <= avg_mode;
            end

            // Write after clear: the written entry stays valid.
            if (clr) ent_vld <= '0;
            out_valid <= s1_vld;
            if (s1_vld) begin
                buf_re[s1_addr]  <= wr_re;
                buf_im[s1_addr]  <= wr_im;
                ent_vld[s1_addr] <= 1'b1;
                out_real         <= wr_re;
                out_imag         <= wr_im;
            end

            // Reads sample the pre-edge buffer, so a colliding write is not seen.
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_hit  <= ent_vld[rd_addr];
                rd_real <= ent_vld[rd_addr] ? buf_re[rd_addr] : '0;
                rd_imag <= ent_vld[rd_addr] ? buf_im[rd_addr] : '0;
            end
        end else begin
            out_valid <= 1'b0;
            rd_valid  <= 1'b0;
        end
    end

endmodule
